demux_stream_scheduler: RTL and testbench
=========================================

# demux_stream_scheduler

Sequencing controller for the 1-to-N demultiplexer datapath. It accepts a single valid/ready input stream and steers each word to one of N output channels. Steering is either round-robin across the enabled channels or directed by a per-word destination field. Each channel has a one-entry output register, so downstream stalls on one channel never corrupt traffic on another.

## Interface
- WIDTH, 8, data word width
- N, 4, number of output channels (power of two, 2..16)
- SELW, 2, destination width, equal to log2(N)

- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous and active-high
- in_valid  input  1  input word present
- in_data  input  WIDTH  input word
- in_dest  input  SELW  destination channel, used only in directed mode
- in_ready  output  1  scheduler can take the word this cycle (combinational)
- mode  input  1  0 = round-robin, 1 = directed
- en_mask  input  N  per-channel enable
- out_valid  output  N  per-channel word valid
- out_data  output  N*WIDTH  channel i data at bits [i*WIDTH +: WIDTH]
- out_ready  input  N  per-channel consumer ready
- drop_cnt  output  8  saturating count of dropped words

## Operation
- Per-channel state: one holding register plus a full flag. out_valid[i] equals full[i].
- Channel i is free this cycle when !full[i], or when full[i] && out_ready[i] (drain and refill in the same cycle).
- Target selection, round-robin (mode = 0):
  - Target is the first enabled channel found searching upward from rr_ptr, modulo N.
  - If en_mask is all zero, there is no target and in_ready = 0.
- Target selection, directed (mode = 1): target = in_dest.
- in_ready:
  - Round-robin: 1 when a target exists and the target is free.
  - Directed, target enabled: in_ready = free[in_dest].
  - Directed, target disabled: in_ready = 1; the word is dropped.
- Accept = in_valid && in_ready.
  - On accept to an enabled target t: data is loaded into register t and full[t] is set.
  - On accept in round-robin mode: rr_ptr <= (t+1) mod N.
  - In directed mode rr_ptr is unchanged.
- Drop = accept in directed mode with en_mask[in_dest] = 0.
  - drop_cnt increments and saturates at 255.
  - No register changes.
- Drain: when full[i] && out_ready[i], full[i] clears unless channel i is refilled in the same cycle.
- Round-robin does not skip a busy target. If the selected target is full and not draining, in_ready = 0. Ordering is strict: word k goes to the k-th enabled channel in rotation.
- Clearing en_mask[i] while full[i] = 1 does not flush the word; the channel still presents it until it is taken.
- mode, en_mask and in_dest are sampled combinationally every cycle. There is no change-request handshake.
- rr_ptr is SELW bits wide and wraps naturally from N-1 to 0.

## Timing
- Reset (asynchronous assert, synchronous release on clk):
  - out_valid = 0, out_data = 0, rr_ptr = 0, drop_cnt = 0.
  - in_ready is 0 while rst is high.
- Latency: a word accepted at edge k appears on out_valid/out_data immediately after edge k (one register stage).
- Throughput: one word per cycle whenever the target is free, including drain-and-refill on the same channel.
- out_data[i] holds stable while out_valid[i] && !out_ready[i].
- Reset asserted mid-transfer discards all held words immediately. No output handshake completes in that cycle.
- In-flight occupancy is never lost; a word is counted only once, either delivered or dropped.

## Test plan
- **Round-robin basic:** reset, mode = 0, en_mask = 4'b1111, all out_ready = 1, send 0x10..0x17 back-to-back. Required: channels 0,1,2,3,0,1,2,3 each see one word per cycle; in_ready stays 1.
- **Skipping disabled channels:** en_mask = 4'b0101, send 0xA0, 0xA1, 0xA2. Required: they land on channels 0, 2, 0; rr_ptr = 1 afterward.
- **Backpressure:** en_mask = 4'b1111, out_ready[1] = 0, send four words. Required: the word for channel 1 is held and in_ready = 0 when rotation returns to channel 1. Raising out_ready[1] drains it and accepts the next word in the same cycle.
- **Directed mode with drops:** mode = 1, en_mask = 4'b0011, send dest 0, 1, 3, 3 with data 0x01..0x04. Required: 0x01 on channel 0, 0x02 on channel 1, drop_cnt = 2. Then send 300 words to dest 3. Required: drop_cnt = 255.
- **All disabled:** en_mask = 0, mode = 0, in_valid = 1. Required: in_ready = 0 and no out_valid for 10 cycles.
- **Reset mid-operation:** three channels full, rst pulsed asynchronously between edges. Required: out_valid = 0 immediately, drop_cnt = 0, and the first word after release goes to channel 0.

Source files
------------

// File: rtl/demux_stream_scheduler_if.sv
// ---------------------------------------------------------------------------
// demux_stream_scheduler_if
// Bundles the input stream, the steering controls and the per-channel output
// handshakes of the 1-to-N demux scheduler.
//   in_valid/in_data/in_dest/in_ready : single input stream (valid/ready)
//   mode/en_mask                      : steering mode and channel enables
//   out_valid/out_data/out_ready      : N output channels, channel i data at
//                                       out_data[i*WIDTH +: WIDTH]
//   drop_cnt                          : saturating count of dropped words
// master = stream producer / channel consumers, slave = scheduler.
// ---------------------------------------------------------------------------
interface demux_stream_scheduler_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
);
    logic                 in_valid;
    logic [WIDTH-1:0]     in_data;
    logic [SELW-1:0]      in_dest;
    logic                 in_ready;
    logic                 mode;
    logic [N-1:0]         en_mask;
    logic [N-1:0]         out_valid;
    logic [N*WIDTH-1:0]   out_data;
    logic [N-1:0]         out_ready;
    logic [7:0]           drop_cnt;

    modport master (
        output in_valid, in_data, in_dest, mode, en_mask, out_ready,
        input  in_ready, out_valid, out_data, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in_dest, mode, en_mask, out_ready,
        output in_ready, out_valid, out_data, drop_cnt
    );
endinterface

// File: rtl/demux_stream_scheduler.sv
// ---------------------------------------------------------------------------
// demux_stream_scheduler
// Steers each word of one valid/ready input stream into one of N one-entry
// output registers, either in strict round-robin order over the enabled
// channels (mode = 0) or by the per-word destination field (mode = 1).
// Directed words aimed at a disabled channel are accepted and dropped, and
// counted in a saturating 8-bit counter.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous active-high reset
//   io_bus : demux_stream_scheduler_if.slave (stream in, channels out)
// ---------------------------------------------------------------------------
module demux_stream_scheduler #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    demux_stream_scheduler_if.slave  io_bus
);

    logic [N-1:0]      r_full;
    logic [WIDTH-1:0]  r_data [N];
    logic [SELW-1:0]   r_rr_ptr;
    logic [7:0]        r_drop_cnt;

    logic [N-1:0]      w_free;
    logic              w_rr_found;
    logic [SELW-1:0]   w_rr_tgt;
    logic [SELW-1:0]   w_idx;
    logic [SELW-1:0]   w_tgt;
    logic              w_tgt_en;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_load;
    logic              w_drop;

    // A channel can take a word when empty, or when its word leaves this cycle
    always_comb begin
        w_free = ~r_full | io_bus.out_ready;
    end

    // Round-robin: first enabled channel at or above the pointer, wrapping
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_tgt   = r_rr_ptr;
        w_idx      = r_rr_ptr;
        for (int k = 0; k < N; k++) begin
            w_idx = r_rr_ptr + SELW'(k);
            if (!w_rr_found && io_bus.en_mask[w_idx]) begin
                w_rr_found = 1'b1;
                w_rr_tgt   = w_idx;
            end else begin
                w_rr_found = w_rr_found;
            end
        end
    end

    // Target channel and whether it may actually be written
    always_comb begin
        w_tgt    = w_rr_tgt;
        w_tgt_en = w_rr_found;
        if (io_bus.mode) begin
            w_tgt    = io_bus.in_dest;
            w_tgt_en = io_bus.en_mask[io_bus.in_dest];
        end else begin
            w_tgt    = w_rr_tgt;
            w_tgt_en = w_rr_found;
        end
    end

    // Ready: a disabled directed target always accepts (the word is dropped);
    // round-robin never skips past a busy target, preserving rotation order
    always_comb begin
        w_in_ready = 1'b0;
        if (rst) begin
            w_in_ready = 1'b0;
        end else if (io_bus.mode && !w_tgt_en) begin
            w_in_ready = 1'b1;
        end else begin
            w_in_ready = w_tgt_en && w_free[w_tgt];
        end
    end

    // Transfer qualifiers for this cycle
    always_comb begin
        w_accept = io_bus.in_valid && w_in_ready;
        w_load   = w_accept && w_tgt_en;
        w_drop   = w_accept && io_bus.mode && !w_tgt_en;
    end

    // Channel registers, rotation pointer and drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full     <= {N{1'b0}};
            r_rr_ptr   <= {SELW{1'b0}};
            r_drop_cnt <= 8'd0;
            for (int i = 0; i < N; i++) begin
                r_data[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                // a refill wins over a drain, so the full flag stays set
                if (w_load && (w_tgt == SELW'(i))) begin
                    r_full[i] <= 1'b1;
                    r_data[i] <= io_bus.in_data;
                end else if (r_full[i] && io_bus.out_ready[i]) begin
                    r_full[i] <= 1'b0;
                end else begin
                    r_full[i] <= r_full[i];
                end
            end
            if (w_accept && !io_bus.mode) begin
                r_rr_ptr <= w_tgt + SELW'(1'b1);
            end else begin
                r_rr_ptr <= r_rr_ptr;
            end
            if (w_drop && (r_drop_cnt != 8'd255)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_valid = r_full;
    assign io_bus.drop_cnt  = r_drop_cnt;

    for (genvar g = 0; g < N; g++) begin : g_out
        assign io_bus.out_data[g*WIDTH +: WIDTH] = r_data[g];
    end

endmodule

// File: tb/tb_demux_stream_scheduler.sv
// ---------------------------------------------------------------------------
// tb_demux_stream_scheduler
// Self-checking bench: a reference model predicts in_ready, channel occupancy
// and drop count each cycle; accepted words are pushed into per-channel
// scoreboard queues and popped/compared when the channel hands them off.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_demux_stream_scheduler;
    localparam int WIDTH = 8;
    localparam int N     = 4;
    localparam int SELW  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_stream_scheduler_if #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) bus ();

    demux_stream_scheduler #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] sb_q [N][$];
    logic [N-1:0]     m_full;
    logic [SELW-1:0]  m_rr;
    logic [7:0]       m_drop;
    logic             last_ready;
    int               last_ch;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) sb_q[i].delete();
        m_full = '0;
        m_rr   = '0;
        m_drop = 8'd0;
    endtask

    // One clock: predict, compare at the negative edge, advance model after posedge
    task automatic cycle();
        logic [N-1:0]    free;
        logic [N-1:0]    n_full;
        logic            found;
        logic [SELW-1:0] tgt;
        logic [SELW-1:0] c;
        logic            en_t;
        logic            exp_ready;
        logic            acc;
        logic [SELW-1:0] n_rr;
        logic [7:0]      n_drop;
        logic [WIDTH-1:0] d;
        @(negedge clk);
        free  = ~m_full | bus.out_ready;
        found = 1'b0;
        tgt   = '0;
        if (bus.mode) begin
            tgt       = bus.in_dest;
            en_t      = bus.en_mask[tgt];
            exp_ready = en_t ? free[tgt] : 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                c = m_rr + SELW'(k);
                if (!found && bus.en_mask[c]) begin
                    found = 1'b1;
                    tgt   = c;
                end
            end
            en_t      = found;
            exp_ready = found && free[tgt];
        end
        last_ready = bus.in_ready;
        last_ch    = -1;
        check_eq("in_ready", bus.in_ready, exp_ready);
        check_eq("drop_cnt", bus.drop_cnt, m_drop);
        check_eq("out_valid", bus.out_valid, m_full);
        n_full = m_full;
        for (int i = 0; i < N; i++) begin
            if (m_full[i] && bus.out_ready[i]) begin
                d = sb_q[i].pop_front();
                check_eq($sformatf("ch%0d_data", i), bus.out_data[i*WIDTH +: WIDTH], d);
                n_full[i] = 1'b0;
            end
        end
        acc    = bus.in_valid && exp_ready;
        n_rr   = m_rr;
        n_drop = m_drop;
        if (acc && en_t) begin
            sb_q[tgt].push_back(bus.in_data);
            n_full[tgt] = 1'b1;
            last_ch     = int'(tgt);
        end
        if (acc && !bus.mode) n_rr = tgt + SELW'(1);
        if (acc && bus.mode && !en_t && m_drop != 8'd255) n_drop = m_drop + 8'd1;
        @(posedge clk);
        #1;
        m_full = n_full;
        m_rr   = n_rr;
        m_drop = n_drop;
    endtask

    task automatic send(input logic [WIDTH-1:0] data, input logic [SELW-1:0] dest);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        bus.in_dest  = dest;
        cycle();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int skip_exp [3];
        int dir_dest [4];
        skip_exp = '{0, 2, 0};
        dir_dest = '{0, 1, 3, 3};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_dest   = '0;
        bus.mode      = 1'b0;
        bus.en_mask   = 4'b1111;
        bus.out_ready = 4'b1111;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_out_valid", bus.out_valid, 4'b0000);
        check_eq("rst_out_data", bus.out_data, 32'h0);
        check_eq("rst_drop_cnt", bus.drop_cnt, 8'd0);
        check_eq("rst_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // round-robin basic, back to back
        bus.in_valid = 1'b1;
        for (int w = 0; w < 8; w++) begin
            bus.in_data = 8'h10 + 8'(w);
            cycle();
            check_eq("rr_basic_ch", last_ch, w % 4);
            check_eq("rr_basic_ready", last_ready, 1'b1);
        end
        bus.in_valid = 1'b0;
        cycle();

        // skip disabled channels
        bus.en_mask = 4'b0101;
        for (int w = 0; w < 3; w++) begin
            send(8'hA0 + 8'(w), '0);
            check_eq("skip_ch", last_ch, skip_exp[w]);
        end
        cycle();

        // backpressure on channel 1; the pointer left at 1 by the skip test
        bus.en_mask   = 4'b1111;
        bus.out_ready = 4'b1101;
        bus.in_valid  = 1'b1;
        for (int w = 0; w < 4; w++) begin
            bus.in_data = 8'hB0 + 8'(w);
            cycle();
            check_eq("bp_ch", last_ch, (w + 1) % 4);
        end
        bus.in_data = 8'hB4;
        repeat (2) begin
            cycle();
            check_eq("bp_stall", last_ready, 1'b0);
        end
        bus.out_ready = 4'b1111;
        cycle();
        check_eq("bp_refill_ready", last_ready, 1'b1);
        check_eq("bp_refill_ch", last_ch, 1);
        bus.in_valid = 1'b0;
        cycle();

        // directed mode with drops
        bus.mode    = 1'b1;
        bus.en_mask = 4'b0011;
        for (int w = 0; w < 4; w++) begin
            send(8'(w + 1), SELW'(dir_dest[w]));
            check_eq("dir_ch", last_ch, (w < 2) ? w : -1);
        end
        cycle();
        check_eq("dir_drop2", bus.drop_cnt, 8'd2);
        bus.in_valid = 1'b1;
        bus.in_dest  = 2'd3;
        for (int w = 0; w < 300; w++) begin
            bus.in_data = 8'(w);
            cycle();
        end
        bus.in_valid = 1'b0;
        cycle();
        check_eq("dir_drop_sat", bus.drop_cnt, 8'd255);

        // all channels disabled
        bus.mode     = 1'b0;
        bus.en_mask  = 4'b0000;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        repeat (10) begin
            cycle();
            check_eq("dis_ready", last_ready, 1'b0);
            check_eq("dis_out_valid", bus.out_valid, 4'b0000);
        end
        bus.in_valid = 1'b0;

        // reset mid-operation with three channels held
        bus.en_mask   = 4'b1111;
        bus.out_ready = 4'b0000;
        for (int w = 0; w < 3; w++) send(8'hD0 + 8'(w), '0);
        check_eq("pre_rst_full", 32'($countones(bus.out_valid)), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_out_valid", bus.out_valid, 4'b0000);
        check_eq("mid_rst_drop_cnt", bus.drop_cnt, 8'd0);
        check_eq("mid_rst_in_ready", bus.in_ready, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 4'b1111;
        send(8'hC0, '0);
        check_eq("post_rst_ch", last_ch, 0);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
